// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared NCO constants and sweep state encoding
package nco_pkg;

  localparam int FCW_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/fcw_sweep_if.sv
// rtl/fcw_sweep_if.sv - control and fcw output bundle of the frequency sweeper
interface fcw_sweep_if
  import nco_pkg::*;
#(
  parameter int N = FCW_W,
  parameter int D = 16
);

  logic         start;
  logic         abort;
  logic [N-1:0] f_lo;
  logic [N-1:0] f_hi;
  logic [N-1:0] step;
  logic [D-1:0] dwell;
  logic [N-1:0] fcw;
  logic         busy;
  logic         done;
  logic         dir;

  modport master (
    output start, abort, f_lo, f_hi, step, dwell,
    input  fcw, busy, done, dir
  );

  modport slave (
    input  start, abort, f_lo, f_hi, step, dwell,
    output fcw, busy, done, dir
  );

endinterface

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable down-counter timing how long each fcw value is held
module dwell_timer #(
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [D-1:0] value,
  output logic         expired
);

  logic [D-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/fcw_sweep.sv
// rtl/fcw_sweep.sv - stepped linear fcw sweep for the NCO
// FCW_SWEEP_BIDIR_EN adds a continuous triangle sweep (DOWN state, dir output).
module fcw_sweep
  import nco_pkg::*;
#(
  parameter int N = FCW_W,
  parameter int D = 16
) (
  input  logic      clk,
  input  logic      reset,
  fcw_sweep_if.slave sw
);

  sweep_state_t state_q, state_d;
  logic [N-1:0] fcw_q, fcw_d;
  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] step_q, step_d;
  logic [D-1:0] dwell_q, dwell_d;
  logic         degen_q, degen_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         dir_q, dir_d;
  logic         tmr_load;
  logic [D-1:0] tmr_value;
  logic         tmr_expired;

  // Sum formed one bit wider so a step past the top of the range saturates instead of wrapping.
  function automatic logic [N-1:0] up_step(input logic [N-1:0] cur, input logic [N-1:0] inc,
                                           input logic [N-1:0] lim);
    logic [N:0] nxt;
    nxt = {1'b0, cur} + {1'b0, inc};
    if (nxt < {1'b0, lim}) up_step = nxt[N-1:0];
    else                   up_step = lim;
  endfunction

`ifdef FCW_SWEEP_BIDIR_EN
  logic [N-1:0] lo_q, lo_d;

  function automatic logic [N-1:0] dn_step(input logic [N-1:0] cur, input logic [N-1:0] dec,
                                           input logic [N-1:0] lim);
    if ((cur > lim) && ((cur - lim) > dec)) dn_step = cur - dec;
    else                                     dn_step = lim;
  endfunction
`endif

  dwell_timer #(.D(D)) u_dwell_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fcw_q   <= '0;
      hi_q    <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      degen_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
`ifdef FCW_SWEEP_BIDIR_EN
      lo_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      fcw_q   <= fcw_d;
      hi_q    <= hi_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      degen_q <= degen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
`ifdef FCW_SWEEP_BIDIR_EN
      lo_q    <= lo_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    fcw_d     = fcw_q;
    hi_d      = hi_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    degen_d   = degen_q;
    done_d    = 1'b0;
    dir_d     = dir_q;
    tmr_load  = 1'b0;
    tmr_value = dwell_q;
`ifdef FCW_SWEEP_BIDIR_EN
    lo_d      = lo_q;
`endif

    if (sw.abort) begin
      state_d = IDLE;
      dir_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sw.start) begin
            hi_d      = sw.f_hi;
            step_d    = sw.step;
            dwell_d   = sw.dwell;
            degen_d   = (sw.f_lo >= sw.f_hi) || (sw.step == '0);
            fcw_d     = sw.f_lo;
            tmr_load  = 1'b1;
            tmr_value = sw.dwell;
            dir_d     = 1'b0;
            state_d   = UP;
`ifdef FCW_SWEEP_BIDIR_EN
            lo_d      = sw.f_lo;
`endif
          end
        end
        UP: begin
          if (tmr_expired) begin
            if (degen_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (fcw_q != hi_q) begin
              fcw_d    = up_step(fcw_q, step_q, hi_q);
              tmr_load = 1'b1;
            end else begin
`ifdef FCW_SWEEP_BIDIR_EN
              fcw_d    = dn_step(fcw_q, step_q, lo_q);
              dir_d    = 1'b1;
              tmr_load = 1'b1;
              state_d  = DOWN;
`else
              state_d  = IDLE;
              done_d   = 1'b1;
`endif
            end
          end
        end
`ifdef FCW_SWEEP_BIDIR_EN
        DOWN: begin
          // Turning at f_lo moves straight to the next ascending value so f_lo is held only once.
          if (tmr_expired) begin
            tmr_load = 1'b1;
            if (fcw_q != lo_q) begin
              fcw_d = dn_step(fcw_q, step_q, lo_q);
            end else begin
              fcw_d   = up_step(fcw_q, step_q, hi_q);
              dir_d   = 1'b0;
              done_d  = 1'b1;
              state_d = UP;
            end
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign sw.fcw  = fcw_q;
  assign sw.busy = busy_q;
  assign sw.done = done_q;
`ifdef FCW_SWEEP_BIDIR_EN
  assign sw.dir  = dir_q;
`else
  assign sw.dir  = 1'b0;
`endif

endmodule

// File: tb/tb_fcw_sweep.sv
// tb/tb_fcw_sweep.sv - directed self-checking bench for fcw_sweep
module tb_fcw_sweep;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fcw_sweep_if #(.N(16), .D(16)) sw ();

  fcw_sweep #(.N(16), .D(16)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [15:0] exp_fcw, input logic exp_busy,
                           input logic exp_done);
    n_checks++;
    if (sw.fcw !== exp_fcw || sw.busy !== exp_busy || sw.done !== exp_done || sw.dir !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: fcw=%0d busy=%b done=%b dir=%b expected fcw=%0d busy=%b done=%b dir=0",
               name, sw.fcw, sw.busy, sw.done, sw.dir, exp_fcw, exp_busy, exp_done);
    end
  endtask

  task automatic launch(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] st,
                        input logic [15:0] dw);
    sw.f_lo  = lo;
    sw.f_hi  = hi;
    sw.step  = st;
    sw.dwell = dw;
    sw.start = 1'b1;
    tick();
    sw.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    check_out("reset", 16'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_out("reset_idle", 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_basic_sweep();
    logic [15:0] exp [12];
    exp = '{16'd100, 16'd100, 16'd100, 16'd110, 16'd110, 16'd110,
            16'd120, 16'd120, 16'd120, 16'd130, 16'd130, 16'd130};
    launch(16'd100, 16'd130, 16'd10, 16'd2);
    for (int i = 0; i < 12; i++) begin
      check_out($sformatf("basic_c%0d", i), exp[i], 1'b1, 1'b0);
      tick();
    end
    check_out("basic_done", 16'd130, 1'b0, 1'b1);
    tick();
    check_out("basic_after", 16'd130, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    logic [15:0] exp [4];
    exp = '{16'd0, 16'd10, 16'd20, 16'd25};
    launch(16'd0, 16'd25, 16'd10, 16'd0);
    for (int i = 0; i < 4; i++) begin
      check_out($sformatf("sat_c%0d", i), exp[i], 1'b1, 1'b0);
      tick();
    end
    check_out("sat_done", 16'd25, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_no_wrap();
    logic [15:0] exp [4];
    exp = '{16'hFFF0, 16'hFFF0, 16'hFFFF, 16'hFFFF};
    launch(16'hFFF0, 16'hFFFF, 16'h0020, 16'd1);
    for (int i = 0; i < 4; i++) begin
      check_out($sformatf("nowrap_c%0d", i), exp[i], 1'b1, 1'b0);
      tick();
    end
    check_out("nowrap_done", 16'hFFFF, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_abort();
    launch(16'd100, 16'd130, 16'd10, 16'd2);
    tick();
    tick();
    tick();
    check_out("abort_pre", 16'd110, 1'b1, 1'b0);
    sw.abort = 1'b1;
    sw.start = 1'b1;
    tick();
    sw.abort = 1'b0;
    sw.start = 1'b0;
    check_out("abort_next", 16'd110, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("abort_idle%0d", i), 16'd110, 1'b0, 1'b0);
    end
  endtask

  task automatic test_degenerate();
    launch(16'd50, 16'd50, 16'd5, 16'd3);
    for (int i = 0; i < 4; i++) begin
      check_out($sformatf("degen_c%0d", i), 16'd50, 1'b1, 1'b0);
      sw.f_lo  = 16'd7;
      sw.dwell = 16'd0;
      sw.start = (i == 1);
      tick();
      sw.start = 1'b0;
    end
    check_out("degen_done", 16'd50, 1'b0, 1'b1);
    tick();
    launch(16'd200, 16'd100, 16'd10, 16'd0);
    check_out("inv_c0", 16'd200, 1'b1, 1'b0);
    tick();
    check_out("inv_done", 16'd200, 1'b0, 1'b1);
    tick();
    launch(16'd10, 16'd90, 16'd0, 16'd1);
    check_out("zstep_c0", 16'd10, 1'b1, 1'b0);
    tick();
    check_out("zstep_c1", 16'd10, 1'b1, 1'b0);
    tick();
    check_out("zstep_done", 16'd10, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    launch(16'd300, 16'd400, 16'd20, 16'd0);
    tick();
    tick();
    check_out("rst_mid_pre", 16'd340, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_out("rst_mid", 16'd0, 1'b0, 1'b0);
    tick();
    check_out("rst_mid_after", 16'd0, 1'b0, 1'b0);
  endtask

`ifdef FCW_SWEEP_BIDIR_EN
  task automatic test_bidir();
    logic [15:0] exp_f [9];
    logic        exp_d [9];
    logic        exp_dn [9];
    exp_f  = '{16'd0, 16'd10, 16'd20, 16'd10, 16'd0, 16'd10, 16'd20, 16'd10, 16'd0};
    exp_d  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    launch(16'd0, 16'd20, 16'd10, 16'd0);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (sw.fcw !== exp_f[i] || sw.dir !== exp_d[i] || sw.done !== exp_dn[i] || sw.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bidir_c%0d: fcw=%0d dir=%b done=%b busy=%b expected fcw=%0d dir=%b done=%b busy=1",
                 i, sw.fcw, sw.dir, sw.done, sw.busy, exp_f[i], exp_d[i], exp_dn[i]);
      end
      tick();
    end
    sw.abort = 1'b1;
    tick();
    sw.abort = 1'b0;
    n_checks++;
    if (sw.busy !== 1'b0 || sw.dir !== 1'b0 || sw.done !== 1'b0) begin
      n_fail++;
      $display("FAIL bidir_abort: busy=%b dir=%b done=%b expected 0 0 0", sw.busy, sw.dir, sw.done);
    end
    tick();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    sw.start = 1'b0;
    sw.abort = 1'b0;
    sw.f_lo  = '0;
    sw.f_hi  = '0;
    sw.step  = '0;
    sw.dwell = '0;
    test_reset();
`ifdef FCW_SWEEP_BIDIR_EN
    test_bidir();
`else
    test_basic_sweep();
    test_saturate();
    test_no_wrap();
    test_abort();
    test_degenerate();
`endif
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
